linescanner_capture_ctrl: RTL
=============================

# linescanner_capture_ctrl

- Parametrised line-scan sensor controller with runtime-programmable timing.
- Drives the sensor reset/sample sequence (rst_cvc, rst_cds, sample) with per-phase durations set from configuration ports. Supports continuous and single-shot line triggering.
- Captures the pixel stream framed by lval into a registered, indexed pixel stream with line markers, a line counter and sticky framing errors.
- Sits between the sensor pads and the downstream line buffer / image processing pipeline.

## Interface
Parameters:
- DATA_WIDTH, 8: sensor pixel width.
- TIMER_WIDTH, 16: width of phase timing config and internal wait counter.
- PIXELS_PER_LINE, 1024: expected lval-high cycles per line.
- IDX_WIDTH, 16: width of pixel_index; must hold PIXELS_PER_LINE-1.
- LINE_CNT_WIDTH, 16: width of line_count.

Ports:
- main_clock_source, in, 1: sole clock, all logic on rising edge.
- n_reset, in, 1: synchronous, active-low reset.
- enable, in, 1: gates starting a new sequence.
- mode, in, 1: 0 = continuous, 1 = single-shot.
- start, in, 1: single-shot trigger, sampled in IDLE only.
- cfg_t_cvc, in, TIMER_WIDTH: rst_cvc-fall to rst_cds-fall delay, in cycles.
- cfg_t_cds, in, TIMER_WIDTH: rst_cds-fall to ADC-wait delay, in cycles.
- cfg_t_sample, in, TIMER_WIDTH: sample high width, in cycles.
- cfg_t_post, in, TIMER_WIDTH: sample-fall to rst release delay, in cycles.
- end_adc, in, 1: sensor ADC conversion done.
- lval, in, 1: sensor line-valid.
- data, in, DATA_WIDTH: sensor pixel data.
- err_clear, in, 1: clears sticky errors.
- rst_cvc, out, 1: sensor reset, active-low pulse.
- rst_cds, out, 1: sensor reset, active-low pulse.
- sample, out, 1: sample strobe, active-high.
- busy, out, 1: sequencer not in IDLE.
- pixel_data, out, DATA_WIDTH: registered pixel.
- pixel_valid, out, 1: pixel_data valid this cycle.
- pixel_index, out, IDX_WIDTH: index of the current pixel.
- line_start, out, 1: one-cycle pulse with pixel 0.
- line_end, out, 1: one-cycle pulse on the cycle after lval falls.
- line_count, out, LINE_CNT_WIDTH: completed lines, wraps to 0.
- err_overrun, out, 1: sticky error.
- err_short, out, 1: sticky error.

## Operation
Reset (n_reset low at an edge):
- Outputs go to rst_cvc=1, rst_cds=1, sample=0, busy=0, pixel_valid=0, line_start=0, line_end=0, pixel_data=0, pixel_index=0, line_count=0, err_*=0.
- Sequencer goes to IDLE.
- Reset mid-sequence or mid-line aborts immediately; no partial line_end is produced.

Sequencer states:
- IDLE: leaves when enable && (mode==0 || start). On leaving:
  - snapshot all four cfg_* values (mid-sequence cfg changes have no effect);
  - rst_cvc<=0;
  - go to T_CVC.
- T_CVC: waits max(cfg_t_cvc,1) cycles, then rst_cds<=0 and go to T_CDS.
- T_CDS: waits max(cfg_t_cds,1) cycles, then go to WAIT_ADC.
- WAIT_ADC: holds indefinitely until end_adc=1, then sample<=1 and go to T_SAMPLE.
- T_SAMPLE: waits max(cfg_t_sample,1) cycles, then sample<=0 and go to T_POST.
- T_POST: waits max(cfg_t_post,1) cycles, then rst_cvc<=1, rst_cds<=1 and go to IDLE.
- IDLE is always occupied at least 1 cycle, so the rst release pulse is ≥1 cycle.
- A cfg value of 0 behaves as 1.
- enable low only blocks leaving IDLE; a running sequence completes.
- start outside IDLE is ignored (not queued).

Capture path (independent of sequencer state):
- Every cycle: pixel_data<=data and pixel_valid<=lval, qualified as below.
- Pixel counter pcnt:
  - on each lval-high cycle, pixel_index<=pcnt and pcnt increments;
  - pcnt clears on the cycle lval is low.
- line_start=1 with the pixel whose index is 0.
- line_end:
  - when lval is seen falling (was 1, now 0), line_end<=1 next cycle;
  - line_count increments on that same edge.
- Overrun: on lval-high cycles with pcnt ≥ PIXELS_PER_LINE:
  - pixel_valid<=0;
  - err_overrun<=1;
  - pcnt saturates.
- Short line: on an lval fall with pcnt < PIXELS_PER_LINE:
  - err_short<=1;
  - line_end and line_count still fire.
- err_clear clears both errors; a simultaneous set wins over clear.

## Timing
- All outputs are registered.
- Capture latency: data/lval to pixel_data/pixel_valid is 1 cycle.
- Sequencer latency, with edge E the IDLE exit:
  - rst_cvc falls at E;
  - rst_cds falls at E+T1;
  - WAIT_ADC is entered at E+T1+T2;
  - sample rises 1 cycle after end_adc is first sampled high in WAIT_ADC, and stays high exactly T3 cycles;
  - rst_cvc/rst_cds rise T4 cycles after sample falls.
- Continuous mode, end_adc held high: period = T1+T2+1+T3+T4+1 cycles.
- end_adc high before WAIT_ADC is ignored; only the level in WAIT_ADC counts.

## Test plan
- Reset then idle:
  - stimulus: n_reset low 3 cycles, enable=0;
  - required: reset values on every output, busy=0, no rst pulse.
- Continuous timing:
  - stimulus: T1=98, T2=7, T3=98, T4=6, end_adc=1;
  - required: rst_cvc low 98+7+1+98+6=210 cycles, rst_cds low 112, sample high exactly 98, period 211.
- Single-shot and edge cases:
  - mode=1 with one start pulse gives exactly one sequence;
  - start during busy is ignored;
  - cfg=0 gives 1-cycle phases;
  - cfg changed mid-sequence has no effect until the next sequence.
- Nominal line (PIXELS_PER_LINE=16):
  - stimulus: 16 lval cycles with data=index;
  - required: pixel_index 0..15 matching data, line_start on index 0, line_end 1 cycle after the last pixel, line_count=1, no errors.
- Overrun and short line:
  - 18 lval cycles gives 16 valid pixels and err_overrun=1;
  - 10 lval cycles gives err_short=1 with line_end;
  - err_clear clears both.
- Reset mid-line and mid-WAIT_ADC:
  - required: next cycle all outputs at reset values, no line_end, line_count=0.

Source files
------------

// File: rtl/linescanner_capture_ctrl_if.sv
// rtl/linescanner_capture_ctrl_if.sv - sensor sequencer and pixel capture signal bundle
interface linescanner_capture_ctrl_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMER_WIDTH    = 16,
  parameter int IDX_WIDTH      = 16,
  parameter int LINE_CNT_WIDTH = 16
);
  logic                      enable;
  logic                      mode;
  logic                      start;
  logic [TIMER_WIDTH-1:0]    cfg_t_cvc;
  logic [TIMER_WIDTH-1:0]    cfg_t_cds;
  logic [TIMER_WIDTH-1:0]    cfg_t_sample;
  logic [TIMER_WIDTH-1:0]    cfg_t_post;
  logic                      end_adc;
  logic                      lval;
  logic [DATA_WIDTH-1:0]     data;
  logic                      err_clear;
  logic                      rst_cvc;
  logic                      rst_cds;
  logic                      sample;
  logic                      busy;
  logic [DATA_WIDTH-1:0]     pixel_data;
  logic                      pixel_valid;
  logic [IDX_WIDTH-1:0]      pixel_index;
  logic                      line_start;
  logic                      line_end;
  logic [LINE_CNT_WIDTH-1:0] line_count;
  logic                      err_overrun;
  logic                      err_short;

  modport master (
    output enable, mode, start, cfg_t_cvc, cfg_t_cds, cfg_t_sample, cfg_t_post,
           end_adc, lval, data, err_clear,
    input  rst_cvc, rst_cds, sample, busy, pixel_data, pixel_valid, pixel_index,
           line_start, line_end, line_count, err_overrun, err_short
  );

  modport slave (
    input  enable, mode, start, cfg_t_cvc, cfg_t_cds, cfg_t_sample, cfg_t_post,
           end_adc, lval, data, err_clear,
    output rst_cvc, rst_cds, sample, busy, pixel_data, pixel_valid, pixel_index,
           line_start, line_end, line_count, err_overrun, err_short
  );
endinterface

// File: rtl/linescanner_capture_ctrl.sv
// rtl/linescanner_capture_ctrl.sv - line-scan sensor reset/sample sequencer and framed pixel capture
module linescanner_capture_ctrl #(
  parameter int DATA_WIDTH      = 8,
  parameter int TIMER_WIDTH     = 16,
  parameter int PIXELS_PER_LINE = 1024,
  parameter int IDX_WIDTH       = 16,
  parameter int LINE_CNT_WIDTH  = 16
) (
  input logic                       main_clock_source,
  input logic                       n_reset,
  linescanner_capture_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, T_CVC, T_CDS, WAIT_ADC, T_SAMPLE, T_POST} state_e;

  localparam logic [TIMER_WIDTH-1:0] T_ONE = TIMER_WIDTH'(1);
  localparam logic [IDX_WIDTH:0]     PPL   = (IDX_WIDTH+1)'(PIXELS_PER_LINE);

  state_e                   state_q, state_d;
  logic [TIMER_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TIMER_WIDTH-1:0]   t_cds_q, t_cds_d, t_sample_q, t_sample_d, t_post_q, t_post_d;
  logic                     rst_cvc_q, rst_cvc_d, rst_cds_q, rst_cds_d, sample_q, sample_d;
  logic                     busy_q;

  logic [IDX_WIDTH:0]       pcnt_q, pcnt_d;
  logic                     lval_q, lval_fall;
  logic [DATA_WIDTH-1:0]    pixel_data_q;
  logic                     pixel_valid_q, pixel_valid_d;
  logic [IDX_WIDTH-1:0]     pixel_index_q, pixel_index_d;
  logic                     line_start_q, line_start_d, line_end_q;
  logic [LINE_CNT_WIDTH-1:0] line_count_q, line_count_d;
  logic                     err_overrun_q, err_overrun_d, err_short_q, err_short_d;

  // A programmed duration of 0 is treated as a single cycle.
  function automatic logic [TIMER_WIDTH-1:0] eff(input logic [TIMER_WIDTH-1:0] v);
    return (v == '0) ? T_ONE : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_cds_d    = t_cds_q;
    t_sample_d = t_sample_q;
    t_post_d   = t_post_q;
    rst_cvc_d  = rst_cvc_q;
    rst_cds_d  = rst_cds_q;
    sample_d   = sample_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && (!bus.mode || bus.start)) begin
          cnt_d      = eff(bus.cfg_t_cvc);
          t_cds_d    = eff(bus.cfg_t_cds);
          t_sample_d = eff(bus.cfg_t_sample);
          t_post_d   = eff(bus.cfg_t_post);
          rst_cvc_d  = 1'b0;
          state_d    = T_CVC;
        end
      end
      T_CVC: begin
        if (cnt_q == T_ONE) begin
          cnt_d     = t_cds_q;
          rst_cds_d = 1'b0;
          state_d   = T_CDS;
        end else cnt_d = cnt_q - T_ONE;
      end
      T_CDS: begin
        if (cnt_q == T_ONE) state_d = WAIT_ADC;
        else cnt_d = cnt_q - T_ONE;
      end
      WAIT_ADC: begin
        if (bus.end_adc) begin
          cnt_d    = t_sample_q;
          sample_d = 1'b1;
          state_d  = T_SAMPLE;
        end
      end
      T_SAMPLE: begin
        if (cnt_q == T_ONE) begin
          cnt_d    = t_post_q;
          sample_d = 1'b0;
          state_d  = T_POST;
        end else cnt_d = cnt_q - T_ONE;
      end
      T_POST: begin
        if (cnt_q == T_ONE) begin
          rst_cvc_d = 1'b1;
          rst_cds_d = 1'b1;
          state_d   = IDLE;
        end else cnt_d = cnt_q - T_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lval_fall = lval_q && !bus.lval;

  // pcnt saturates at PIXELS_PER_LINE, so at a falling lval it holds the captured length.
  always_comb begin
    pcnt_d        = pcnt_q;
    pixel_index_d = pixel_index_q;
    pixel_valid_d = 1'b0;
    line_start_d  = 1'b0;
    line_count_d  = line_count_q;
    err_overrun_d = err_overrun_q && !bus.err_clear;
    err_short_d   = err_short_q && !bus.err_clear;
    if (bus.lval) begin
      if (pcnt_q < PPL) begin
        pixel_valid_d = 1'b1;
        pixel_index_d = pcnt_q[IDX_WIDTH-1:0];
        line_start_d  = (pcnt_q == '0);
        pcnt_d        = pcnt_q + (IDX_WIDTH+1)'(1);
      end else err_overrun_d = 1'b1;
    end else pcnt_d = '0;
    if (lval_fall) begin
      line_count_d = line_count_q + LINE_CNT_WIDTH'(1);
      if (pcnt_q < PPL) err_short_d = 1'b1;
    end
  end

  always_ff @(posedge main_clock_source) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      t_cds_q       <= '0;
      t_sample_q    <= '0;
      t_post_q      <= '0;
      rst_cvc_q     <= 1'b1;
      rst_cds_q     <= 1'b1;
      sample_q      <= 1'b0;
      busy_q        <= 1'b0;
      pcnt_q        <= '0;
      lval_q        <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      line_start_q  <= 1'b0;
      line_end_q    <= 1'b0;
      line_count_q  <= '0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      t_cds_q       <= t_cds_d;
      t_sample_q    <= t_sample_d;
      t_post_q      <= t_post_d;
      rst_cvc_q     <= rst_cvc_d;
      rst_cds_q     <= rst_cds_d;
      sample_q      <= sample_d;
      busy_q        <= (state_d != IDLE);
      pcnt_q        <= pcnt_d;
      lval_q        <= bus.lval;
      pixel_data_q  <= bus.data;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      line_start_q  <= line_start_d;
      line_end_q    <= lval_fall;
      line_count_q  <= line_count_d;
      err_overrun_q <= err_overrun_d;
      err_short_q   <= err_short_d;
    end
  end

  assign bus.rst_cvc     = rst_cvc_q;
  assign bus.rst_cds     = rst_cds_q;
  assign bus.sample      = sample_q;
  assign bus.busy        = busy_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_index = pixel_index_q;
  assign bus.line_start  = line_start_q;
  assign bus.line_end    = line_end_q;
  assign bus.line_count  = line_count_q;
  assign bus.err_overrun = err_overrun_q;
  assign bus.err_short   = err_short_q;
endmodule
